// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial receiver slice.
// Pure declarations; no clocked logic, no latency or backpressure.
package sipo_pkg;

  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  // True when the bit index points at the last data bit of a frame.
  function automatic logic is_last_bit(input logic [2:0] idx);
    return idx == 3'(FRAME_BITS - 1);
  endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Serial line in, framed byte out with valid/frame_err strobes and busy status.
// Wires only; no latency; strobes have no backpressure, data holds until next good frame.
interface sipo_rx_if;
  import sipo_pkg::*;

  logic                  serial_in;
  logic [FRAME_BITS-1:0] data;
  logic                  valid;
  logic                  frame_err;
  logic                  busy;

  modport master (
    input  serial_in,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  modport slave (
    output serial_in,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface

// File: rtl/sipo_bit_timer.sv
// N-bit bit-period timer with mid-bit and end-of-bit compare ticks.
// Ticks are combinational compares on the registered count; no backpressure.
module sipo_bit_timer #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic half_tick,
  output logic full_tick
);

  localparam logic [N-1:0] HALF = N'((1 << (N - 1)) - 1);
  localparam logic [N-1:0] FULL = '1;

  logic [N-1:0] cnt;

  // Wraps naturally at 2^N so DATA can sample back-to-back bits without a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + N'(1);
    end
  end

  assign half_tick = (cnt == HALF);
  assign full_tick = (cnt == FULL);

endmodule

// File: rtl/sipo_rx.sv
// Serial frame receiver: 2-flop sync, mid-bit sampling, byte out; valid 1 clk after stop sample.
// No backpressure: valid/frame_err are single-cycle strobes, data holds the last good byte.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int N = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  sipo_rx_if.master bus
);

  logic                  sync1;
  logic                  rx_s;
  state_t                state;
  state_t                state_nxt;
  logic [FRAME_BITS-1:0] shift;
  logic [2:0]            bit_idx;
  logic [FRAME_BITS-1:0] data_r;
  logic                  valid_r;
  logic                  ferr_r;

  logic timer_clr;
  logic half_tick;
  logic full_tick;
  logic shift_en;
  logic idx_clr;
  logic load;
  logic ferr_set;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.serial_in;
      rx_s  <= sync1;
    end
  end

  sipo_bit_timer #(.N(N)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clr),
    .enable    (state != IDLE),
    .half_tick (half_tick),
    .full_tick (full_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    idx_clr   = 1'b0;
    load      = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
        end
      end
      START: begin
        if (half_tick) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            idx_clr   = 1'b1;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (is_last_bit(bit_idx)) begin
            state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rx_s) begin
            load      = 1'b1;
            state_nxt = IDLE;
          end else begin
            ferr_set  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        // Held-low line parks here so it cannot be re-read as a stream of frames.
        if (rx_s) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    timer_clr = (state_nxt != state);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      if (shift_en) begin
        shift <= {shift[FRAME_BITS-2:0], rx_s};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      valid_r <= load;
      ferr_r  <= ferr_set;
      if (load) begin
        data_r <= shift;
      end
    end
  end

  assign bus.data      = data_r;
  assign bus.valid     = valid_r;
  assign bus.frame_err = ferr_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench: N=2 receiver for framing cases, N=4 receiver for glitch rejection.
module tb_sipo_rx;
  import sipo_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sipo_rx_if if2 ();
  sipo_rx_if if4 ();

  sipo_rx #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));
  sipo_rx #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.master));

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // N=2 monitor
  int vld2 = 0, ferr2 = 0, both2 = 0, wide2 = 0, busy_seen2 = 0;
  int vld_cyc2 = 0, prev_vld_cyc2 = 0, ferr_cyc2 = 0;
  logic [7:0] dq2[$];
  logic v_q2 = 1'b0, f_q2 = 1'b0;
  always @(negedge clk) begin
    if (if2.valid === 1'b1) begin
      vld2++;
      prev_vld_cyc2 = vld_cyc2;
      vld_cyc2 = cyc;
      dq2.push_back(if2.data);
      if (v_q2) wide2++;
    end
    if (if2.frame_err === 1'b1) begin
      ferr2++;
      ferr_cyc2 = cyc;
      if (f_q2) wide2++;
    end
    if (if2.valid === 1'b1 && if2.frame_err === 1'b1) both2++;
    if (if2.busy === 1'b1) busy_seen2++;
    v_q2 = (if2.valid === 1'b1);
    f_q2 = (if2.frame_err === 1'b1);
  end

  // N=4 monitor
  int vld4 = 0, ferr4 = 0, rise4 = 0, fall4 = 0;
  logic b_q4 = 1'b0;
  always @(negedge clk) begin
    if (if4.valid === 1'b1) vld4++;
    if (if4.frame_err === 1'b1) ferr4++;
    if (if4.busy === 1'b1 && !b_q4) rise4 = cyc;
    if (if4.busy !== 1'b1 && b_q4) fall4 = cyc;
    b_q4 = (if4.busy === 1'b1);
  end

  // Called just after a negedge; drives start, 8 bits MSB-first, stop at 4 clk/bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int fall);
    logic [9:0] bits;
    bits = {1'b0, b, stop_bit};
    fall = cyc;
    for (int i = 9; i >= 0; i--) begin
      if2.serial_in = bits[i];
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    int f1, f2, base_v, base_f, base4, basef4;
    logic [7:0] fb;

    rst_n = 1'b0;
    if2.serial_in = 1'b0;
    if4.serial_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", if2.data, 8'h00);
    chk("rst_valid", if2.valid, 1'b0);
    chk("rst_ferr", if2.frame_err, 1'b0);
    chk("rst_busy", if2.busy, 1'b0);
    chk("rst_busy4", if4.busy, 1'b0);

    if2.serial_in = 1'b1;
    if4.serial_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_valid", vld2, 0);
    chk("idle_ferr", ferr2, 0);
    chk("idle_busy", busy_seen2, 0);

    // Single frame A5
    send_frame(8'hA5, 1'b1, f1);
    repeat (4) @(negedge clk);
    chk("a5_count", vld2, 1);
    chk("a5_latency", vld_cyc2 - f1, 41);
    chk("a5_data", if2.data, 8'hA5);
    chk("a5_width", wide2, 0);

    // Back-to-back 07 then FF
    base_v = vld2;
    send_frame(8'h07, 1'b1, f1);
    send_frame(8'hFF, 1'b1, f2);
    repeat (4) @(negedge clk);
    chk("b2b_count", vld2 - base_v, 2);
    chk("b2b_spacing", vld_cyc2 - prev_vld_cyc2, 40);
    chk("b2b_first", dq2[base_v], 8'h07);
    chk("b2b_second", dq2[base_v+1], 8'hFF);
    chk("b2b_width", wide2, 0);

    // Framing error: 3C with low stop, line held low
    base_v = vld2;
    base_f = ferr2;
    send_frame(8'h3C, 1'b0, f1);
    repeat (20) @(negedge clk);
    chk("break_busy", if2.busy, 1'b1);
    if2.serial_in = 1'b1;
    repeat (8) @(negedge clk);
    chk("ferr_count", ferr2 - base_f, 1);
    chk("ferr_latency", ferr_cyc2 - f1, 41);
    chk("ferr_no_valid", vld2 - base_v, 0);
    chk("ferr_data_kept", if2.data, 8'hFF);
    chk("ferr_idle", if2.busy, 1'b0);
    chk("ferr_width", wide2, 0);

    base_v = vld2;
    send_frame(8'h81, 1'b1, f1);
    repeat (4) @(negedge clk);
    chk("post_err_count", vld2 - base_v, 1);
    chk("post_err_data", if2.data, 8'h81);

    // One-cycle glitch on the N=4 receiver
    base4 = vld4;
    basef4 = ferr4;
    if4.serial_in = 1'b0;
    f1 = cyc;
    @(negedge clk);
    if4.serial_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("glitch_rise", rise4 - f1, 3);
    chk("glitch_fall", fall4 - f1, 11);
    chk("glitch_valid", vld4 - base4, 0);
    chk("glitch_ferr", ferr4 - basef4, 0);

    // Reset after the 4th data bit of F0
    base_v = vld2;
    fb = 8'hF0;
    if2.serial_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 4; i--) begin
      if2.serial_in = fb[i];
      repeat (4) @(negedge clk);
    end
    rst_n = 1'b0;
    if2.serial_in = 1'b1;
    #1;
    chk("midrst_data", if2.data, 8'h00);
    chk("midrst_busy", if2.busy, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_idle", if2.busy, 1'b0);
    send_frame(8'h55, 1'b1, f1);
    repeat (4) @(negedge clk);
    chk("midrst_count", vld2 - base_v, 1);
    chk("midrst_data55", if2.data, 8'h55);

    chk("never_both", both2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
